// File: rtl/beacon_pkg.sv
// beacon_pkg: shared definitions for the beacon transmit arbiter.
//   state_t    frame sequencer state encoding
//   SYNC_WORD  sync pattern that opens every frame (sent MSB first)
//   SYNC_LEN   sync pattern length in bits
//   clog2()    elaboration-time ceiling log2, used to size the ID field and counters
package beacon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ID,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_t;

  localparam int SYNC_LEN = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1011;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/manchester_enc.sv
// manchester_enc: one-bit Manchester encoder with a registered line output.
//   A bit loaded at a clock edge appears as its first half-bit (bit ^ 0) in the
//   following cycle and its second half-bit (bit ^ 1) in the cycle after. With
//   no new load after the second half the line returns to 0.
// Ports:
//   clk       in   clock, one half-bit per cycle
//   rst_n     in   asynchronous active-low reset
//   load      in   load bit_in at this edge (starts a new bit)
//   bit_in    in   bit to encode
//   signal    out  registered Manchester line, 0 when idle
//   bit_done  out  high during the second half-bit cycle; a load at the end of
//                  this cycle makes the next bit follow with no gap
module manchester_enc
  import beacon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic bit_in,
  output logic signal,
  output logic bit_done
);

  logic bit_q;
  logic phase;
  logic live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q    <= 1'b0;
      phase    <= 1'b0;
      live     <= 1'b0;
      signal   <= 1'b0;
      bit_done <= 1'b0;
    end else if (load) begin
      bit_q    <= bit_in;
      phase    <= 1'b0;
      live     <= 1'b1;
      signal   <= bit_in ^ 1'b0;
      bit_done <= 1'b0;
    end else if (live && !phase) begin
      phase    <= 1'b1;
      signal   <= bit_q ^ 1'b1;
      bit_done <= 1'b1;
    end else begin
      // Bit finished and nothing queued: drop the line low.
      phase    <= 1'b0;
      live     <= 1'b0;
      signal   <= 1'b0;
      bit_done <= 1'b0;
    end
  end

endmodule

// File: rtl/beacon_tx_arbiter.sv
// beacon_tx_arbiter: shares one Manchester-coded beacon pin between NUM_REQ
// requesters. A round-robin arbiter picks one requester in IDLE, captures its
// status word, and the sequencer sends SYNC | ID | DATA [| PARITY] followed by
// GAP_BITS idle bit-times with the line low.
// Build option: define BEACON_PARITY_EN to append one even-parity bit over
// {ID, DATA}; the frame then grows by 2 cycles.
// Parameters:
//   NUM_REQ   number of requesters (>= 2), ID field is clog2(NUM_REQ) bits
//   DATA_W    status word width, sent MSB first
//   GAP_BITS  idle bit-times after each frame (>= 1)
// Ports:
//   clk     in   clock, one half-bit per cycle
//   rst_n   in   asynchronous active-low reset; abandons any frame in flight
//   req     in   level requests, held until the matching gnt is seen
//   data    in   requester i status word at [i*DATA_W +: DATA_W]
//   gnt     out  one-hot 1-cycle pulse marking the capture of a word
//   busy    out  high from the capture edge until the end of the gap
//   done    out  1-cycle pulse in the last gap cycle
//   signal  out  registered Manchester line, 0 when idle
module beacon_tx_arbiter
  import beacon_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      done,
  output logic                      signal
);

  localparam int ID_W = clog2(NUM_REQ);
`ifdef BEACON_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int FRAME_BITS = SYNC_LEN + ID_W + DATA_W + PAR_W;
  localparam int GAP_CYC    = 2 * GAP_BITS;
  // One counter serves every field (bits left) and the gap (cycles left).
  localparam int CNT_W      = clog2(FRAME_BITS + GAP_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                  state;
  logic [ID_W-1:0]         ptr;
  logic [CNT_W-1:0]        cnt;
  logic [FRAME_BITS-1:0]   shreg;

  logic [ID_W-1:0]         win;
  logic                    found;
  int                      arb_idx;
  logic [DATA_W-1:0]       win_data;
  logic [FRAME_BITS-1:0]   frame_w;
  logic                    enc_load;
  logic                    enc_bit;
  logic                    bit_done;
  logic                    last_bit;

  // Round-robin pick: first asserted request at or after ptr, wrapping.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    arb_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx = int'(ptr) + i;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!found && req[arb_idx]) begin
        win   = ID_W'(arb_idx);
        found = 1'b1;
      end
    end
  end

  assign win_data = data[int'(win)*DATA_W +: DATA_W];

`ifdef BEACON_PARITY_EN
  assign frame_w  = {SYNC_WORD, win, win_data, ^{win, win_data}};
  assign last_bit = (state == ST_PAR);
`else
  assign frame_w  = {SYNC_WORD, win, win_data};
  assign last_bit = (state == ST_DATA) && (cnt == '0);
`endif

  // Feed the encoder: first sync bit on the capture edge, then the next frame
  // bit each time the current one finishes, except after the final bit.
  always_comb begin
    enc_load = 1'b0;
    enc_bit  = 1'b0;
    case (state)
      ST_IDLE: begin
        enc_load = |req;
        enc_bit  = frame_w[FRAME_BITS-1];
      end
      ST_SYNC, ST_ID, ST_DATA, ST_PAR: begin
        enc_load = bit_done && !last_bit;
        enc_bit  = shreg[FRAME_BITS-1];
      end
      default: ;
    endcase
  end

  // Shift register holds the frame bits not yet handed to the encoder.
  always_ff @(posedge clk) begin
    if (enc_load) begin
      if (state == ST_IDLE) shreg <= {frame_w[FRAME_BITS-2:0], 1'b0};
      else                  shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt   <= NUM_REQ'(1) << win;
            ptr   <= (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
            busy  <= 1'b1;
            state <= ST_SYNC;
            cnt   <= CNT_W'(SYNC_LEN - 1);
          end
        end
        ST_SYNC: begin
          if (bit_done) begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
            else begin
              state <= ST_ID;
              cnt   <= CNT_W'(ID_W - 1);
            end
          end
        end
        ST_ID: begin
          if (bit_done) begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
            else begin
              state <= ST_DATA;
              cnt   <= CNT_W'(DATA_W - 1);
            end
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
            else begin
`ifdef BEACON_PARITY_EN
              state <= ST_PAR;
              cnt   <= '0;
`else
              state <= ST_GAP;
              cnt   <= CNT_W'(GAP_CYC - 1);
`endif
            end
          end
        end
`ifdef BEACON_PARITY_EN
        ST_PAR: begin
          if (bit_done) begin
            state <= ST_GAP;
            cnt   <= CNT_W'(GAP_CYC - 1);
          end
        end
`endif
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt - CNT_ONE;
            done <= (cnt == CNT_ONE);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  manchester_enc u_enc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (enc_load),
    .bit_in   (enc_bit),
    .signal   (signal),
    .bit_done (bit_done)
  );

endmodule
